// File: rtl/dac_pkg.sv
// Shared definitions for the LTC2624-style quad DAC SPI transmitter.
// Holds the command and address codes, the 32-bit frame layout, the
// transmitter state encoding and a helper that packs one frame.
package dac_pkg;

  localparam int FRAME_BITS = 32;

  // Field positions inside the 32-bit frame (upper byte is always zero)
  localparam int CMD_LSB  = 20;
  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 4;

  localparam logic [3:0] CMD_WRITE        = 4'b0000;
  localparam logic [3:0] CMD_UPDATE       = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;

  localparam logic [3:0] ADDR_A   = 4'h0;
  localparam logic [3:0] ADDR_B   = 4'h1;
  localparam logic [3:0] ADDR_C   = 4'h2;
  localparam logic [3:0] ADDR_D   = 4'h3;
  localparam logic [3:0] ADDR_ALL = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_TAIL,
    S_HOLD,
    S_DONE
  } state_e;

  // Packs command/address/code into the frame; don't-care bits stay zero
  function automatic logic [FRAME_BITS-1:0] buildFrame(
    input logic [3:0]  cmd,
    input logic [3:0]  addr,
    input logic [11:0] code
  );
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[CMD_LSB  +: 4]  = cmd;
    f[ADDR_LSB +: 4]  = addr;
    f[DATA_LSB +: 12] = code;
    return f;
  endfunction

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Half-period timer for the SPI serial clock.
// Ports:
//   clk_i    - system clock
//   rst_i    - synchronous active-high reset
//   load_i   - restart a fresh half-period starting next cycle
//   en_i     - count while high
//   expire_o - one-cycle strobe on the last cycle of each CLK_DIV-cycle period
module spi_halfperiod_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int              CW     = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts down to zero and reloads itself, so back-to-back half-periods
  // need no extra load; it never goes below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI transmitter for the serial quad 12-bit DAC (32-bit frame).
// Shifts one frame out MSB-first on a trigger, captures the DAC's SDO echo,
// and reports completion with a one-cycle done pulse.
// Ports:
//   CLK50MHZ, RST           - system clock, synchronous active-high reset
//   data/address/command    - frame contents, latched on an accepted trigger
//   dactrig                 - start request, honoured only when idle
//   dacdone                 - one-cycle completion pulse
//   dac_datareceived        - 32-bit word captured from DAC_OUT
//   busy                    - high while a frame is in progress
//   SPI_SCK/SPI_MOSI/DAC_CS - SPI bus (SCK idles low, CS active-low)
//   DAC_CLR                 - DAC clear, active-low, released after reset
//   DAC_OUT                 - serial echo from the DAC
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_HOLD = 2
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  input  logic [11:0] data,
  input  logic [3:0]  address,
  input  logic [3:0]  command,
  input  logic        dactrig,
  output logic        dacdone,
  output logic [31:0] dac_datareceived,
  output logic        busy,
  output logic        SPI_SCK,
  output logic        DAC_CS,
  output logic        DAC_CLR,
  output logic        SPI_MOSI,
  input  logic        DAC_OUT
);

  localparam int                HOLD_W      = $clog2(CS_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(CS_HOLD - 1);
  localparam logic [5:0]        BIT_COUNT   = 6'(FRAME_BITS);

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [FRAME_BITS-1:0]   rxWord_q, rxWord_d;
  logic [5:0]              bits_q, bits_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    clr_q;
  logic                    timerLoad;
  logic                    inFrame;
  logic                    halfExpire;

  assign inFrame = (state_q == S_LOW) || (state_q == S_HIGH) || (state_q == S_TAIL);

  // LOW, HIGH and TAIL are all one half-period long and follow each other
  // directly, so a single free-running timer started at the trigger paces them.
  spi_halfperiod_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk_i    (CLK50MHZ),
    .rst_i    (RST),
    .load_i   (timerLoad),
    .en_i     (inFrame),
    .expire_o (halfExpire)
  );

  // Next-state and datapath updates. The echo bit is taken as SCK rises
  // (LOW->HIGH), the TX register shifts as SCK falls so MOSI settles a full
  // low half-period before the next rising edge.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rxWord_d  = rxWord_q;
    bits_d    = bits_q;
    hold_d    = hold_q;
    timerLoad = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dactrig) begin
          tx_d      = buildFrame(command, address, data);
          rx_d      = '0;
          bits_d    = BIT_COUNT;
          timerLoad = 1'b1;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (halfExpire) begin
          rx_d    = {rx_q[FRAME_BITS-2:0], DAC_OUT};
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (halfExpire) begin
          bits_d = bits_q - 6'd1;
          if (bits_q != 6'd1) begin
            tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
            state_d = S_LOW;
          end else begin
            state_d = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (halfExpire) begin
          hold_d  = HOLD_RELOAD;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          rxWord_d = rx_q;
          state_d  = S_DONE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; DAC_CLR is held low only while in reset
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q  <= S_IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      rxWord_q <= '0;
      bits_q   <= '0;
      hold_q   <= '0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxWord_q <= rxWord_d;
      bits_q   <= bits_d;
      hold_q   <= hold_d;
      clr_q    <= 1'b1;
    end
  end

  assign SPI_SCK          = (state_q == S_HIGH);
  assign DAC_CS           = ~inFrame;
  assign SPI_MOSI         = tx_q[FRAME_BITS-1];
  assign busy             = (state_q != S_IDLE);
  assign dacdone          = (state_q == S_DONE);
  assign DAC_CLR          = clr_q;
  assign dac_datareceived = rxWord_q;

endmodule
